// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings (md_op_e) as used on the op port
//   - controller state encoding (md_state_e)
//   - MD_ITER: iterations per multiply/divide (one result bit per clock)
package mult_div_unit_pkg;

  localparam int DATA_W  = 32;
  localparam int MD_ITER = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // True for the ops that run through the 32-iteration datapath.
  function automatic logic is_iter_op(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit iterative multiply/divide unit with HI/LO registers.
//   Multiply: radix-2 shift-add, divide: restoring, one bit per clock.
//   Signed ops work on magnitudes and fix the signs on the final iteration.
// Ports:
//   clk     in   1   clock, rising edge
//   rst     in   1   synchronous active-high reset
//   start   in   1   request strobe, only looked at in IDLE
//   op      in   3   operation code (md_op_e)
//   a       in  32   multiplicand / dividend / MTHI-MTLO source
//   b       in  32   multiplier / divisor
//   cancel  in   1   aborts an operation while in CALC
//   busy    out  1   high in CALC and DONE
//   done    out  1   one-cycle completion pulse (DONE state)
//   hi      out 32   HI register (product high word / remainder)
//   lo      out 32   LO register (product low word / quotient)
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] CNT_LAST = 6'(MD_ITER - 1);

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

  md_state_e   state, state_nxt;
  logic [5:0]  cnt;
  logic        accept, last_iter;

  // Operand capture
  logic        sa_in, sb_in;
  logic [31:0] mag_a, mag_b;

  // Iteration datapath state (no reset: qualified by the controller)
  logic [64:0] acc;
  logic [31:0] opa, opb;
  logic        is_mul, neg_q, neg_r;

  // Shared adder/subtractor and next-iteration value
  logic [32:0] add_x, add_y, sum33;
  logic [64:0] acc_nxt;

  // Final results presented at the last iteration
  logic [63:0] prod_s;
  logic [31:0] res_hi, res_lo;

  assign accept    = (state == ST_IDLE) && start && is_iter_op(op);
  assign last_iter = (state == ST_CALC) && (cnt == CNT_LAST);

  // ---- controller: state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---- controller: next state ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: begin
        if (cancel)         state_nxt = ST_IDLE;
        else if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- controller: outputs ----
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // ---- operand capture (edge 0) ----
  // Even op codes are the signed variants; unsigned ops never negate.
  always_comb begin
    sa_in = ~op[0] & a[31];
    sb_in = ~op[0] & b[31];
    mag_a = cond_neg32(a, sa_in);
    mag_b = cond_neg32(b, sb_in);
  end

  // ---- iteration step ----
  // Multiply: acc = {carry, partial high, multiplier/low product}; add the
  //   multiplicand when acc[0] is set, then shift the whole thing right.
  // Divide: acc = {remainder, dividend/quotient}; shift left one bit, try
  //   subtracting the divisor, keep the difference when it did not borrow.
  always_comb begin
    if (is_mul) begin
      add_x = acc[64:32];
      add_y = acc[0] ? {1'b0, opa} : 33'd0;
    end else begin
      add_x = acc[63:31];
      add_y = ~{1'b0, opb};
    end
    sum33 = add_x + add_y + {32'd0, ~is_mul};

    if (is_mul)
      acc_nxt = {1'b0, sum33, acc[31:1]};
    else if (sum33[32])
      acc_nxt = {1'b0, add_x[31:0], acc[30:0], 1'b0};
    else
      acc_nxt = {1'b0, sum33[31:0], acc[30:0], 1'b1};
  end

  // ---- sign correction of the final iteration ----
  // A zero divisor leaves hi = original dividend (magnitude re-signed with
  // the dividend sign) and lo = all ones.
  always_comb begin
    prod_s = cond_neg64(acc_nxt[63:0], neg_q);
    if (is_mul) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (opb == 32'd0) begin
      res_hi = cond_neg32(opa, neg_r);
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = cond_neg32(acc_nxt[63:32], neg_r);
      res_lo = cond_neg32(acc_nxt[31:0], neg_q);
    end
  end

  // ---- datapath registers ----
  always_ff @(posedge clk) begin
    if (accept) begin
      is_mul <= ~op[1];
      neg_q  <= sa_in ^ sb_in;
      neg_r  <= sa_in;
      opa    <= mag_a;
      opb    <= mag_b;
      acc    <= {33'd0, (op[1] ? mag_a : mag_b)};
    end else if (state == ST_CALC) begin
      acc    <= acc_nxt;
    end
  end

  // ---- iteration counter and HI/LO ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (accept)                  cnt <= '0;
      else if (state == ST_CALC)   cnt <= cnt + 6'd1;

      if ((state == ST_IDLE) && start && (op == OP_MTHI)) hi <= a;
      if ((state == ST_IDLE) && start && (op == OP_MTLO)) lo <= a;

      if (last_iter && !cancel) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases followed by
// randomized operations compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] mhi = '0, mlo = '0;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference HI/LO behaviour from the arithmetic definition of each op.
  task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      3'd0: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
      3'd1: begin p = {32'd0, av} * {32'd0, bv}; mhi = p[63:32]; mlo = p[31:0]; end
      3'd2, 3'd3: begin
        if (bv == 32'd0) begin
          mhi = av; mlo = 32'hFFFF_FFFF;
        end else begin
          if (o == 3'd3) begin
            sa = longint'({32'd0, av});
            sb = longint'({32'd0, bv});
          end
          q = sa / sb;
          r = sa % sb;
          mlo = q[31:0];
          mhi = r[31:0];
        end
      end
      3'd4: mhi = av;
      3'd5: mlo = av;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input bit with_cancel);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; cancel = with_cancel;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0; a = $urandom; b = $urandom;
    model(o, av, bv);
    lat = 0; bcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bcnt += int'(busy);
      if (done) begin lat = n; break; end
    end
    check("latency", 64'(lat), 64'd33);
    check("busy_cycles", 64'(bcnt), 64'd33);
    check("hi", {32'd0, hi}, {32'd0, mhi});
    check("lo", {32'd0, lo}, {32'd0, mlo});
    @(negedge clk);
    check("busy_after", 64'(busy), 64'd0);
    check("done_after", 64'(done), 64'd0);
  endtask

  // Single-edge ops (MTHI/MTLO/reserved): no busy, no done.
  task automatic do_move(input logic [2:0] o, input logic [31:0] av);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom;
    model(o, av, 32'd0);
    @(negedge clk);
    check("move_hi", {32'd0, hi}, {32'd0, mhi});
    check("move_lo", {32'd0, lo}, {32'd0, mlo});
    check("move_busy", 64'(busy), 64'd0);
    check("move_done", 64'(done), 64'd0);
  endtask

  initial begin
    int dn, fnd;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);

    // Directed arithmetic corners
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'd3, 32'd7, 32'd2, 1'b0);
    do_op(3'd2, 32'd100, 32'd0, 1'b0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd0, 1'b1);

    // Cancel mid-divide, then a move
    do_move(3'd4, 32'd5);
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    dn = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); dn += int'(done); end
    @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_hi", {32'd0, hi}, {32'd0, mhi});
    check("cancel_lo", {32'd0, lo}, {32'd0, mlo});
    for (int k = 0; k < 30; k++) begin @(negedge clk); dn += int'(done); end
    check("cancel_no_done", 64'(dn), 64'd0);
    do_move(3'd4, 32'h1234_5678);

    // Start ignored while busy
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'hDEAD_BEEF; b = 32'd1234;
    @(posedge clk);
    #1 start = 1'b0;
    model(3'd3, 32'hDEAD_BEEF, 32'd1234);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 3'd0; a = 32'd77; b = 32'd99;
    @(posedge clk);
    #1 start = 1'b0;
    fnd = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin fnd = 1; break; end
    end
    check("ignored_start_done", 64'(fnd), 64'd1);
    check("ignored_start_hi", {32'd0, hi}, {32'd0, mhi});
    check("ignored_start_lo", {32'd0, lo}, {32'd0, mlo});
    @(negedge clk);

    // Reset mid-multiply
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h0001_2345; b = 32'h0006_789A;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mhi = '0; mlo = '0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); dn += int'(done); end
    check("midrst_no_done", 64'(dn), 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 15))
        0, 1: rb = 32'd0;
        2:    begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:    rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if (ro <= 3'd3) do_op(ro, ra, rb, 1'($urandom_range(0, 1)));
      else            do_move(ro, ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
